noc_packet_injector: RTL and testbench
======================================

Name: noc_packet_injector

Overview:
- Parametrised network-interface injector that sits between a host/traffic source and one local input port of the XNO x YNO mesh (network4x4 and larger).
- Buffers incoming packets in a DEPTH-entry FIFO, checks the destination field against the mesh size, and injects packets with a valid/ready handshake.
- Optional inter-packet gap pacing.
- Keeps saturating injection and drop statistics, plus a sticky overflow flag.

Parameters:
- PACKET_SIZE, 16, packet width in bits.
- XNO, 4, mesh columns.
- YNO, 4, mesh rows.
- DEST_W, 4, destination field width. The field is the top DEST_W bits of the packet. Requires 2^DEST_W >= XNO*YNO.
- DEPTH, 8, FIFO entries. Must be a power of 2 and at least 2.
- GAP_W, 4, width of the pacing gap input.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_data  input  PACKET_SIZE  packet from the host.
- i_data_valid  input  1  i_data is presented this cycle (no backpressure on the host side).
- o_full  output  1  FIFO holds DEPTH entries.
- o_data  output  PACKET_SIZE  packet toward the mesh (the FIFO head).
- o_valid  output  1  o_data is offered to the mesh.
- i_ready  input  1  mesh accepts o_data this cycle.
- i_gap  input  GAP_W  idle cycles to insert after each injected packet.
- i_clr_stats  input  1  synchronous clear of the statistics.
- o_inj_count  output  CNT_W  packets injected.
- o_drop_count  output  CNT_W  packets dropped (bad destination or overflow).
- o_overflow  output  1  sticky: at least one packet was dropped because the FIFO was full.

Behaviour:
- Reset (i_reset_n=0, asynchronous): FIFO empty, pointers 0, gap counter 0. All outputs 0: o_valid, o_full, o_data, o_inj_count, o_drop_count, o_overflow. Reset asserted mid-transfer discards all buffered packets.
- Destination check: dest = i_data[PACKET_SIZE-1 -: DEST_W]. The destination is legal iff dest < XNO*YNO.
- Write (when i_data_valid=1), evaluated with pre-edge state:
  - Illegal destination: packet discarded; o_drop_count increments.
  - Legal destination and FIFO full: packet discarded; o_drop_count increments; o_overflow set to 1. A pop in the same cycle does NOT free space for this write.
  - Otherwise: packet written at the tail and count increments.
- Read/injection:
  - o_valid = (count != 0) && (gap counter == 0).
  - o_data = FIFO head. It must stay stable while o_valid=1 && i_ready=0.
  - A transfer occurs on an edge where o_valid && i_ready. At that edge: pop the head, o_inj_count increments, and the gap counter loads i_gap.
  - While the gap counter is nonzero it decrements each cycle and o_valid=0.
  - i_gap=0 gives back-to-back injection, one packet per cycle while i_ready=1.
- Latency: a packet written into an empty FIFO with gap counter 0 raises o_valid in the cycle after the write edge (1-cycle latency). No combinational path from i_data to o_data.
- Simultaneous push and pop with a non-full FIFO: both occur and count is unchanged.
- Pointers wrap modulo DEPTH. Count is held in clog2(DEPTH)+1 bits.
- o_full is a combinational function of count (count == DEPTH).
- Counters saturate at 2^CNT_W-1.
- i_clr_stats=1: at the next edge o_inj_count, o_drop_count and o_overflow become 0. Clear takes priority over a same-cycle increment or overflow event. Clear does not affect the FIFO or the gap counter.
- i_ready is ignored while o_valid=0.
- No state machine beyond the two-state pacing logic:
  - IDLE_GAP (gap counter > 0).
  - ACTIVE (gap counter == 0).
  - ACTIVE -> IDLE_GAP on a transfer with i_gap > 0.
  - IDLE_GAP -> ACTIVE when the counter reaches 1 and decrements to 0.

Decomposition:
- Shared package noc_pkg:
  - PACKET_SIZE default.
  - DEST_W.
  - A function dest_of(packet).
  - A function node_count(XNO, YNO).
  - Typedef packet_t.
- Sub-module noc_sync_fifo, parametrised by WIDTH and DEPTH. It provides push, pop, full, empty, count and a first-word-fall-through head. The injector wraps it with the destination check, pacing and statistics.

Test Plan:
- Reset then 8 back-to-back legal packets (e.g. 16'h107F, 16'h20FE, 16'h30FF, 16'h41FC, ...), i_gap=0, i_ready=1 -> o_valid rises 1 cycle after the first write; the same 8 words appear in order on consecutive cycles; o_inj_count=8, o_drop_count=0.
- XNO=YNO=2 (4 nodes), send 16'h5123 then 16'h3001 -> 16'h5123 dropped (o_drop_count=1); only 16'h3001 injected (o_inj_count=1).
- i_ready=0, write 10 packets with DEPTH=8 -> o_full=1 after the 8th write; writes 9 and 10 dropped; o_overflow=1, o_drop_count=2; o_data holds the first packet stable. Then i_ready=1 -> exactly 8 packets drain in order.
- i_gap=3, 4 packets queued, i_ready=1 -> transfers spaced 4 cycles apart; o_valid low for exactly 3 cycles between them.
- FIFO full with i_ready=1, push and pop in the same cycle -> push rejected; o_overflow set; count drops from 8 to 7.
- Assert i_clr_stats in the same cycle as a transfer, then assert i_reset_n=0 mid-stream -> counters read 0 after the clear; after reset o_valid=0 and the FIFO is empty.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared types and helpers for the mesh packet injector slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package noc_pkg;

  localparam int DEF_PACKET_SIZE = 16;
  localparam int DEF_DEST_W      = 4;

  typedef logic [DEF_PACKET_SIZE-1:0] packet_t;

  // Pacing state: ACTIVE may inject, IDLE_GAP is counting down idle cycles.
  typedef enum logic {
    ACTIVE   = 1'b0,
    IDLE_GAP = 1'b1
  } pace_state_t;

  // Destination node index carried in the top bits of a packet.
  function automatic logic [DEF_DEST_W-1:0] dest_of(input packet_t pkt);
    return pkt[DEF_PACKET_SIZE-1 -: DEF_DEST_W];
  endfunction

  function automatic int node_count(input int xno, input int yno);
    return xno * yno;
  endfunction

endpackage

// File: rtl/noc_packet_injector_if.sv
// Host-side write bus and mesh-side valid/ready bus of the injector.
// Latency: n/a (wires only).
// Backpressure: mesh side via i_ready; host side has none (o_full is advisory).
// master: traffic source / mesh model; slave: the injector.
interface noc_packet_injector_if #(
  parameter int PACKET_SIZE = noc_pkg::DEF_PACKET_SIZE
);
  logic [PACKET_SIZE-1:0] i_data;
  logic                   i_data_valid;
  logic                   o_full;
  logic [PACKET_SIZE-1:0] o_data;
  logic                   o_valid;
  logic                   i_ready;

  modport master (
    output i_data, i_data_valid, i_ready,
    input  o_full, o_data, o_valid
  );

  modport slave (
    input  i_data, i_data_valid, i_ready,
    output o_full, o_data, o_valid
  );
endinterface

// File: rtl/noc_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head and occupancy count.
// Latency: a pushed word is visible on o_head the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty.
// Ports: i_push/i_data write, i_pop read, o_head/o_full/o_empty/o_count status.
module noc_sync_fifo #(
  parameter  int WIDTH    = 16,
  parameter  int DEPTH    = 8,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_BITS = PTR_W + 1
) (
  input  logic                clk,
  input  logic                i_reset_n,
  input  logic                i_push,
  input  logic [WIDTH-1:0]    i_data,
  input  logic                i_pop,
  output logic [WIDTH-1:0]    o_head,
  output logic                o_full,
  output logic                o_empty,
  output logic [CNT_BITS-1:0] o_count
);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                push_ok, pop_ok;

  assign o_full  = (count_q == CNT_BITS'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_head  = mem_q[rd_ptr_q];

  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_BITS'(1);
      2'b01:   count_d = count_q - CNT_BITS'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= i_data;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/noc_packet_injector.sv
// Mesh local-port injector: destination check, FIFO buffering, gap pacing, stats.
// Latency: 1 cycle from host write to o_valid (empty FIFO, no pending gap).
// Backpressure: head held while i_ready=0; host writes dropped when full.
// Ports: clk/i_reset_n, bus (host write + mesh valid/ready), i_gap pacing,
//        i_clr_stats, o_inj_count/o_drop_count saturating stats, o_overflow sticky.
module noc_packet_injector
  import noc_pkg::*;
#(
  parameter int PACKET_SIZE = DEF_PACKET_SIZE,
  parameter int XNO         = 4,
  parameter int YNO         = 4,
  parameter int DEST_W      = DEF_DEST_W,
  parameter int DEPTH       = 8,
  parameter int GAP_W       = 4,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 i_reset_n,
  noc_packet_injector_if.slave bus,
  input  logic [GAP_W-1:0]     i_gap,
  input  logic                 i_clr_stats,
  output logic [CNT_W-1:0]     o_inj_count,
  output logic [CNT_W-1:0]     o_drop_count,
  output logic                 o_overflow
);

  localparam int CNT_BITS = $clog2(DEPTH) + 1;
  localparam int NODES    = node_count(XNO, YNO);
  // One extra bit so a fully populated destination space still compares correctly.
  localparam logic [DEST_W:0] NODE_LIM = NODES[DEST_W:0];

  logic [DEST_W-1:0]   dest;
  logic                dest_legal;
  logic                fifo_full, fifo_empty;
  logic [CNT_BITS-1:0] fifo_count;
  logic                push, xfer, drop_bad, drop_ovf;

  pace_state_t         state_q;
  logic [GAP_W-1:0]    gap_q;

  logic [CNT_W-1:0]    inj_q, inj_d, drop_q, drop_d;
  logic                ovf_q, ovf_d;

  assign dest       = bus.i_data[PACKET_SIZE-1 -: DEST_W];
  assign dest_legal = ({1'b0, dest} < NODE_LIM);

  // Full is judged on pre-edge occupancy, so a same-cycle pop never makes room.
  assign push     = bus.i_data_valid && dest_legal && !fifo_full;
  assign drop_bad = bus.i_data_valid && !dest_legal;
  assign drop_ovf = bus.i_data_valid && dest_legal && fifo_full;

  assign bus.o_valid = !fifo_empty && (state_q == ACTIVE);
  assign bus.o_full  = (fifo_count == CNT_BITS'(DEPTH));
  assign xfer        = bus.o_valid && bus.i_ready;

  noc_sync_fifo #(
    .WIDTH (PACKET_SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .i_reset_n (i_reset_n),
    .i_push    (push),
    .i_data    (bus.i_data),
    .i_pop     (xfer),
    .o_head    (bus.o_data),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty),
    .o_count   (fifo_count)
  );

  // Pacing: a transfer with a nonzero gap parks the injector for i_gap cycles.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ACTIVE;
      gap_q   <= '0;
    end else begin
      case (state_q)
        ACTIVE: begin
          if (xfer && (i_gap != '0)) begin
            gap_q   <= i_gap;
            state_q <= IDLE_GAP;
          end
        end
        IDLE_GAP: begin
          gap_q <= gap_q - GAP_W'(1);
          if (gap_q == GAP_W'(1)) begin
            state_q <= ACTIVE;
          end
        end
        default: begin
          state_q <= ACTIVE;
          gap_q   <= '0;
        end
      endcase
    end
  end

  // Saturating statistics; clear wins over any same-cycle event.
  always_comb begin
    inj_d  = inj_q;
    drop_d = drop_q;
    ovf_d  = ovf_q | drop_ovf;
    if (xfer && !(&inj_q)) begin
      inj_d = inj_q + CNT_W'(1);
    end
    if ((drop_bad || drop_ovf) && !(&drop_q)) begin
      drop_d = drop_q + CNT_W'(1);
    end
    if (i_clr_stats) begin
      inj_d  = '0;
      drop_d = '0;
      ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      inj_q  <= '0;
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      inj_q  <= inj_d;
      drop_q <= drop_d;
      ovf_q  <= ovf_d;
    end
  end

  assign o_inj_count  = inj_q;
  assign o_drop_count = drop_q;
  assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_noc_packet_injector.sv
// Directed bench for noc_packet_injector on a 2x2 mesh with an 8-entry FIFO.
// Latency: n/a.
// Backpressure: i_ready driven directly by the stimulus.
module tb_noc_packet_injector;
  import noc_pkg::*;

  localparam int DEPTH = 8;
  localparam int NODES = node_count(2, 2);

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic [3:0]  i_gap;
  logic        i_clr_stats;
  logic [15:0] inj_count, drop_count;
  logic        overflow;

  always #5 clk = ~clk;

  noc_packet_injector_if #(.PACKET_SIZE(16)) bus ();

  noc_packet_injector #(
    .PACKET_SIZE (16),
    .XNO         (2),
    .YNO         (2),
    .DEST_W      (4),
    .DEPTH       (DEPTH),
    .GAP_W       (4),
    .CNT_W       (16)
  ) dut (
    .clk          (clk),
    .i_reset_n    (i_reset_n),
    .bus          (bus),
    .i_gap        (i_gap),
    .i_clr_stats  (i_clr_stats),
    .o_inj_count  (inj_count),
    .o_drop_count (drop_count),
    .o_overflow   (overflow)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] exp_q[$];
  int          xfer_cyc[$];
  int          exp_inj = 0;
  int          exp_drop = 0;
  logic        exp_ovf = 1'b0;

  logic [15:0] t1_pkts [8] = '{16'h107F, 16'h20FE, 16'h30FF, 16'h01FC,
                              16'h1234, 16'h2345, 16'h3456, 16'h0567};

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard pops on every handshake seen just before the edge it completes on.
  always @(negedge clk) begin
    if (i_reset_n === 1'b1 && bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_xfer: observed %0h expected no transfer", bus.o_data);
      end
      if (exp_q.size() != 0) begin
        chk("xfer_data", bus.o_data, exp_q.pop_front());
      end
      xfer_cyc.push_back(cyc);
      if (!i_clr_stats) exp_inj++;
    end
  end

  // Drive one host write for one cycle and predict its fate from pre-edge occupancy.
  task automatic send(input logic [15:0] p);
    bus.i_data       = p;
    bus.i_data_valid = 1'b1;
    if (int'(dest_of(p)) >= NODES) begin
      exp_drop++;
    end else if (exp_q.size() >= DEPTH) begin
      exp_drop++;
      exp_ovf = 1'b1;
    end else begin
      exp_q.push_back(p);
    end
    tick();
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL %s: observed %0d pending expected 0", tag, exp_q.size());
    end
  endtask

  task automatic clear_stats();
    i_clr_stats = 1'b1;
    tick();
    i_clr_stats = 1'b0;
    exp_inj  = 0;
    exp_drop = 0;
    exp_ovf  = 1'b0;
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_inj"},  inj_count,  exp_inj);
    chk({tag, "_drop"}, drop_count, exp_drop);
    chk({tag, "_ovf"},  overflow,   exp_ovf);
  endtask

  task automatic check_spacing(input string tag, input int n, input int gap);
    chk({tag, "_xfers"}, xfer_cyc.size(), n);
    for (int k = 1; k < xfer_cyc.size(); k++) begin
      chk({tag, "_spacing"}, xfer_cyc[k] - xfer_cyc[k-1], gap);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset_n        = 1'b0;
    i_gap            = '0;
    i_clr_stats      = 1'b0;
    bus.i_data       = '0;
    bus.i_data_valid = 1'b0;
    bus.i_ready      = 1'b0;
    repeat (2) tick();

    // Reset state
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_full",  bus.o_full, 0);
    chk("rst_data",  bus.o_data, 0);
    check_stats("rst");
    i_reset_n = 1'b1;
    tick();

    // Back-to-back injection, one-cycle latency
    bus.i_ready = 1'b1;
    xfer_cyc.delete();
    chk("t1_valid_pre", bus.o_valid, 0);
    for (int i = 0; i < 8; i++) begin
      send(t1_pkts[i]);
      if (i == 0) chk("t1_latency", bus.o_valid, 1);
    end
    bus.i_data_valid = 1'b0;
    drain("t1_drain", 20);
    check_spacing("t1", 8, 1);
    chk("t1_inj_abs", inj_count, 8);
    check_stats("t1");

    // Destination check, including the boundary node 3 / 4
    clear_stats();
    check_stats("t2_clr");
    send(16'h5123);
    send(16'h3001);
    send(16'h4000);
    send(16'hF000);
    bus.i_data_valid = 1'b0;
    drain("t2_drain", 20);
    chk("t2_drop_abs", drop_count, 3);
    check_stats("t2");

    // Overflow while stalled; head held stable
    clear_stats();
    bus.i_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send(16'h2A00 | 16'(i));
      if (i == 6) chk("t3_not_full", bus.o_full, 0);
      if (i == 7) chk("t3_full", bus.o_full, 1);
      chk("t3_hold", bus.o_data, 16'h2A00);
    end
    bus.i_data_valid = 1'b0;
    chk("t3_valid_stalled", bus.o_valid, 1);
    check_stats("t3_ovf");
    xfer_cyc.delete();
    bus.i_ready = 1'b1;
    drain("t3_drain", 30);
    check_spacing("t3", 8, 1);
    check_stats("t3");

    // Gap pacing
    clear_stats();
    bus.i_ready = 1'b0;
    i_gap = 4'd3;
    for (int i = 0; i < 4; i++) send(16'h1B00 | 16'(i));
    bus.i_data_valid = 1'b0;
    xfer_cyc.delete();
    bus.i_ready = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("t4_gap_low", bus.o_valid, 0);
      tick();
    end
    chk("t4_valid_back", bus.o_valid, 1);
    drain("t4_drain", 40);
    check_spacing("t4", 4, 4);
    check_stats("t4");
    i_gap = 4'd0;

    // Full FIFO with simultaneous push and pop: push rejected
    clear_stats();
    bus.i_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(16'h0C00 | 16'(i));
    chk("t5_full", bus.o_full, 1);
    xfer_cyc.delete();
    bus.i_ready = 1'b1;
    send(16'h0CFF);
    bus.i_data_valid = 1'b0;
    chk("t5_full_after_pop", bus.o_full, 0);
    check_stats("t5_ovf");
    drain("t5_drain", 30);
    check_spacing("t5", 8, 1);
    check_stats("t5");

    // Clear coincident with a transfer, then reset mid-stream
    clear_stats();
    bus.i_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(16'h3D00 | 16'(i));
    bus.i_data_valid = 1'b0;
    bus.i_ready = 1'b1;
    i_clr_stats = 1'b1;
    tick();
    i_clr_stats = 1'b0;
    exp_inj  = 0;
    exp_drop = 0;
    exp_ovf  = 1'b0;
    check_stats("t6_clr");
    i_reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_rst_valid", bus.o_valid, 0);
    chk("t6_rst_full",  bus.o_full, 0);
    chk("t6_rst_data",  bus.o_data, 0);
    tick();
    i_reset_n = 1'b1;
    repeat (2) tick();
    chk("t6_empty_valid", bus.o_valid, 0);
    chk("t6_empty_data",  bus.o_data, 0);
    check_stats("t6_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
